fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the Steel core; replaces the direct PC-to-I_ADDR path that assumed single-cycle, always-ready instruction memory.
- Issues pipelined requests to a variable-latency instruction memory, buffers in-order responses in a prefetch FIFO, and hands instruction/PC pairs to decode with a valid/ready handshake.
- Handles redirects from branch, trap and mret by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Issues pipelined requests to a
//            variable-latency instruction memory, buffers in-order responses
//            in a prefetch FIFO and hands {instruction, PC} pairs to decode
//            over a valid/ready handshake. Redirects flush the buffer and
//            discard stale in-flight responses.
// Ports    : CLK, RESET (sync, active high)
//            I_REQ/I_ADDR/I_GNT             - memory request channel
//            I_RVALID/I_RDATA               - in-order memory responses
//            REDIRECT/REDIRECT_ADDR         - flush and restart fetch
//            INSTR_VALID/INSTR/INSTR_PC/
//            INSTR_MISALIGNED/INSTR_READY   - decode handshake
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        I_REQ,
    output logic [31:0] I_ADDR,
    input  logic        I_GNT,
    input  logic        I_RVALID,
    input  logic [31:0] I_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_ADDR,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    output logic        INSTR_MISALIGNED,
    input  logic        INSTR_READY
);

    localparam int          CW         = $clog2(FIFO_DEPTH + 1);
    localparam int          DW         = $clog2(MAX_OUTSTANDING * 2 + 1);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [CW-1:0] MAX_OUT_C  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_CW   = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DISC_MAX   = {DW{1'b1}};
    localparam logic [31:0]   DISC_MAX32 = 32'(DISC_MAX);

    // Architectural state
    logic [31:0]   pc_q, pc_d;            // next address to request
    logic [31:0]   resp_pc_q, resp_pc_d;  // PC of the next response to keep
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [DW-1:0] discard_q, discard_d;
    logic          halted_q, halted_d;

    // Prefetch storage (data only, validity is carried by count_q)
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic          fifo_mis_q   [FIFO_DEPTH];

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_instr;
    logic [31:0]   wr_pc;
    logic          wr_mis;

    logic          grant;
    logic          accept_resp;
    logic          drop_resp;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [31:0]   disc_sum;
    logic          disc_sat;

    // Requests are throttled by both the outstanding limit and by FIFO
    // credit: every accepted request owns a slot, so a push never overflows.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    assign I_REQ       = ~halted_q & ~REDIRECT & (outst_q < MAX_OUT_C)
                       & (credit_used < DEPTH_C);
    assign I_ADDR      = pc_q;

    assign grant       = I_REQ & I_GNT;
    assign drop_resp   = I_RVALID & (discard_q != '0);
    assign accept_resp = I_RVALID & (discard_q == '0);

    assign INSTR_VALID      = (count_q != '0);
    assign INSTR            = INSTR_VALID ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign INSTR_PC         = INSTR_VALID ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    assign INSTR_MISALIGNED = INSTR_VALID ? fifo_mis_q[rd_ptr_q]   : 1'b0;
    assign pop              = INSTR_VALID & INSTR_READY;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        halted_d  = halted_q;
        wr_en     = 1'b0;
        wr_idx    = wr_ptr_q;
        wr_instr  = I_RDATA;
        wr_pc     = resp_pc_q;
        wr_mis    = 1'b0;
        disc_sum  = 32'(discard_q) + 32'(outst_q);
        disc_sat  = 1'b0;

        if (REDIRECT) begin
            // Everything still in flight becomes stale; a response landing in
            // this very cycle is one of them and is simply not pushed.
            if (I_RVALID && (disc_sum != 32'd0)) begin
                disc_sum = disc_sum - 32'd1;
            end
            if (disc_sum > DISC_MAX32) begin
                discard_d = DISC_MAX;
                disc_sat  = 1'b1;
            end else begin
                discard_d = disc_sum[DW-1:0];
            end
            pc_d      = REDIRECT_ADDR;
            resp_pc_d = REDIRECT_ADDR;
            outst_d   = '0;
            rd_ptr_d  = '0;
            if (REDIRECT_ADDR[1:0] != 2'b00) begin
                // Fault entry travels down the pipe like an instruction so
                // decode raises the trap in order.
                halted_d = 1'b1;
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_instr = NOP_INSTR;
                wr_pc    = REDIRECT_ADDR;
                wr_mis   = 1'b1;
                wr_ptr_d = AW'(1);
                count_d  = CW'(1);
            end else begin
                halted_d = 1'b0;
                wr_ptr_d = '0;
                count_d  = '0;
            end
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(grant) - CW'(accept_resp);
            if (drop_resp) begin
                discard_d = discard_q - DW'(1);
            end
            if (accept_resp) begin
                wr_en     = 1'b1;
                wr_ptr_d  = wr_ptr_q + AW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(accept_resp) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q      <= BOOT_ADDRESS;
            resp_pc_q <= BOOT_ADDRESS;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            halted_q  <= halted_d;
        end
    end

    // Entry contents need no reset: outputs are gated by count_q.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            fifo_instr_q[wr_idx] <= wr_instr;
            fifo_pc_q[wr_idx]    <= wr_pc;
            fifo_mis_q[wr_idx]   <= wr_mis;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (!(wr_en && !REDIRECT && (count_q == DEPTH_CW) && !pop))
                else $error("fetch_unit: push into full prefetch buffer");
            assert (!(REDIRECT && disc_sat))
                else $error("fetch_unit: discard counter saturated");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with an in-order
//            variable-latency memory model and an in-order PC scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic        I_GNT = 1'b0;
    logic        I_RVALID = 1'b0;
    logic [31:0] I_RDATA = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_ADDR = 32'h0;
    logic        INSTR_VALID;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_MISALIGNED;
    logic        INSTR_READY = 1'b0;

    fetch_unit #(
        .BOOT_ADDRESS    (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .I_REQ            (I_REQ),
        .I_ADDR           (I_ADDR),
        .I_GNT            (I_GNT),
        .I_RVALID         (I_RVALID),
        .I_RDATA          (I_RDATA),
        .REDIRECT         (REDIRECT),
        .REDIRECT_ADDR    (REDIRECT_ADDR),
        .INSTR_VALID      (INSTR_VALID),
        .INSTR            (INSTR),
        .INSTR_PC         (INSTR_PC),
        .INSTR_MISALIGNED (INSTR_MISALIGNED),
        .INSTR_READY      (INSTR_READY)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_grant = 0;
    int          n_pop = 0;
    logic [31:0] exp_pc = 32'h0;
    bit          sb_en = 1'b0;
    bit          stab_en = 1'b0;
    bit          out_chk_en = 1'b0;
    bit          lat_rand = 1'b0;
    bit          lat_special = 1'b0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        if (lat_special && (a == 32'h10 || a == 32'h14)) return 8;
        if (lat_rand) return int'($urandom_range(5, 1));
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic mem_reset();
        q_addr.delete();
        q_due.delete();
        I_RVALID = 1'b0;
        I_RDATA  = 32'h0;
    endtask

    // One clock cycle: inspect the pre-edge handshakes, cross the edge,
    // then drive the memory response for the new cycle.
    task automatic step();
        logic g;
        #1;
        if (stab_en && prev_wait) begin
            chk("req_held_while_ungranted", {31'h0, I_REQ}, 32'h1);
            chk("addr_stable_while_ungranted", I_ADDR, prev_addr);
        end
        g         = I_REQ & I_GNT & ~RESET;
        prev_wait = I_REQ & ~I_GNT & ~RESET;
        prev_addr = I_ADDR;
        if (g) begin
            q_addr.push_back(I_ADDR);
            q_due.push_back(cyc + lat_of(I_ADDR));
            n_grant++;
        end
        if (sb_en && INSTR_VALID && INSTR_READY && !REDIRECT && !RESET) begin
            chk("pop_pc", INSTR_PC, exp_pc);
            chk("pop_instr", INSTR, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (REDIRECT) exp_pc = REDIRECT_ADDR;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            I_RVALID = 1'b1;
            I_RDATA  = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            I_RVALID = 1'b0;
            I_RDATA  = 32'h0;
        end
        if (out_chk_en)
            chk("outstanding_le_max", 32'(q_addr.size()) + 32'(I_RVALID), 32'(q_addr.size()) + 32'(I_RVALID) <= 2 ? 32'(q_addr.size()) + 32'(I_RVALID) : 32'd2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int p0;

        // ---------------- reset state ----------------
        RESET = 1'b1; I_GNT = 1'b1; INSTR_READY = 1'b1;
        mem_reset();
        step(); step();
        settle();
        chk("rst_instr_valid", {31'h0, INSTR_VALID}, 32'h0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_instr_pc", INSTR_PC, 32'h0);
        chk("rst_misaligned", {31'h0, INSTR_MISALIGNED}, 32'h0);
        chk("rst_i_addr", I_ADDR, 32'h0);

        // ---------------- streaming ----------------
        RESET = 1'b0; sb_en = 1'b1; exp_pc = 32'h0;
        settle();
        chk("stream_req_first_cycle", {31'h0, I_REQ}, 32'h1);
        chk("stream_valid_c0", {31'h0, INSTR_VALID}, 32'h0);
        step();
        chk("stream_valid_c1", {31'h0, INSTR_VALID}, 32'h0);
        step();
        chk("stream_valid_c2", {31'h0, INSTR_VALID}, 32'h1);
        chk("stream_first_pc", INSTR_PC, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stream_one_per_cycle", {31'h0, INSTR_VALID}, 32'h1);
        end

        // ---------------- reset mid-burst ----------------
        RESET = 1'b1;
        mem_reset();
        step();
        chk("midrst_instr_valid", {31'h0, INSTR_VALID}, 32'h0);
        chk("midrst_i_addr", I_ADDR, 32'h0);

        // ---------------- backpressure ----------------
        RESET = 1'b0; INSTR_READY = 1'b0; exp_pc = 32'h0; n_grant = 0;
        for (int i = 0; i < 20; i++) step();
        settle();
        chk("bp_grants", 32'(n_grant), 32'd4);
        chk("bp_req_held_low", {31'h0, I_REQ}, 32'h0);
        chk("bp_head_valid", {31'h0, INSTR_VALID}, 32'h1);
        chk("bp_head_pc", INSTR_PC, 32'h0);
        INSTR_READY = 1'b1;
        p0 = n_pop; k = 0;
        while (n_pop < p0 + 5 && k < 20) begin step(); k++; end
        chk("bp_release_pops", 32'(n_pop - p0), 32'd5);

        // ---------------- redirect with two in flight ----------------
        RESET = 1'b1; mem_reset(); step(); step();
        RESET = 1'b0; lat_special = 1'b1; exp_pc = 32'h0;
        k = 0;
        while (I_ADDR != 32'h18 && k < 30) begin step(); k++; end
        chk("redir_setup_addr", I_ADDR, 32'h18);
        chk("redir_setup_inflight", 32'(q_addr.size()), 32'd2);
        REDIRECT = 1'b1; REDIRECT_ADDR = 32'h200;
        settle();
        chk("redir_no_req", {31'h0, I_REQ}, 32'h0);
        step();
        REDIRECT = 1'b0;
        chk("redir_flushed", {31'h0, INSTR_VALID}, 32'h0);
        p0 = n_pop; k = 0;
        while (n_pop == p0 && k < 40) begin step(); k++; end
        chk("redir_new_head_popped", 32'(n_pop - p0), 32'd1);
        lat_special = 1'b0;

        // ---------------- response in the redirect cycle ----------------
        for (int i = 0; i < 12; i++) step();
        k = 0;
        while (!I_RVALID && k < 10) begin step(); k++; end
        REDIRECT = 1'b1; REDIRECT_ADDR = 32'h400;
        step();
        REDIRECT = 1'b0;
        p0 = n_pop; k = 0;
        while (n_pop < p0 + 2 && k < 20) begin step(); k++; end
        chk("redir_same_cycle_pops", 32'(n_pop - p0), 32'd2);

        // ---------------- misaligned redirect ----------------
        sb_en = 1'b0; INSTR_READY = 1'b0;
        REDIRECT = 1'b1; REDIRECT_ADDR = 32'h102;
        step();
        REDIRECT = 1'b0;
        k = 0;
        while (!INSTR_VALID && k < 3) begin step(); k++; end
        chk("mis_valid", {31'h0, INSTR_VALID}, 32'h1);
        chk("mis_instr", INSTR, 32'h0000_0013);
        chk("mis_pc", INSTR_PC, 32'h102);
        chk("mis_flag", {31'h0, INSTR_MISALIGNED}, 32'h1);
        settle();
        chk("mis_no_req", {31'h0, I_REQ}, 32'h0);
        INSTR_READY = 1'b1;
        step();
        chk("mis_single_entry", {31'h0, INSTR_VALID}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("halted_no_req", {31'h0, I_REQ}, 32'h0);
            step();
        end
        sb_en = 1'b1;
        REDIRECT = 1'b1; REDIRECT_ADDR = 32'h300;
        step();
        REDIRECT = 1'b0;
        p0 = n_pop; k = 0;
        while (n_pop < p0 + 2 && k < 20) begin step(); k++; end
        chk("resume_after_halt_pops", 32'(n_pop - p0), 32'd2);

        // ---------------- variable latency ----------------
        lat_rand = 1'b1; stab_en = 1'b1; prev_wait = 1'b0; out_chk_en = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 300; i++) begin
            I_GNT       = ($urandom_range(0, 1) == 1);
            INSTR_READY = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("random_progress", 32'(n_pop - p0 > 20), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
